// File: rtl/trashbin_bus_pkg.sv
// Shared types and widths for the on-chip data RAM bus.
// Holds the arbiter FSM state encoding, master identifiers and bus widths.
// No logic; imported by the arbiter and its round-robin selector.
package trashbin_bus_pkg;

    localparam int RAM_ADDR_W = 14;
    localparam int BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arbState_t;

    typedef enum logic {
        MASTER0 = 1'b0,
        MASTER1 = 1'b1
    } masterId_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the winner is taken.
module rr_arb2
    import trashbin_bus_pkg::*;
(
    input  logic [1:0] req,
    input  masterId_t  lastGrant,
    output logic       grantValid,
    output masterId_t  winner
);

    always_comb begin
        grantValid = |req;
        winner     = MASTER0;
        if (req == 2'b11) begin
            // On a tie the master that did not win last time goes next.
            winner = (lastGrant == MASTER0) ? MASTER1 : MASTER0;
        end else if (req[1]) begin
            winner = MASTER1;
        end
    end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares the single-port data RAM between the CPU data port and a second master.
// Latency: request sampled at edge N, RAM access in cycle N+1, ack in cycle N+2.
// Backpressure: a master holds req until its ack; one access per three cycles.
module ram_bus_arbiter
    import trashbin_bus_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic              CoreClock,
    input  logic              Reset,
    input  logic              m0_req,
    input  logic [31:0]       m0_addr,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [31:0]       m1_addr,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    arbState_t         state;
    arbState_t         nextState;
    masterId_t         lastGrant;
    masterId_t         latchId;
    masterId_t         winner;
    logic              grantValid;
    logic              grantNow;
    logic              rdLoad;
    logic [ADDR_W-1:0] latchAddr;
    logic              latchWe;
    logic [DATA_W-1:0] latchWdata;
    logic [DATA_W-1:0] rdHold0;
    logic [DATA_W-1:0] rdHold1;

    // Byte-lane and out-of-range address bits are intentionally ignored.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                              m1_addr[31:ADDR_W+2], m1_addr[1:0]};

    rr_arb2 u_rrArb (
        .req        ({m1_req, m0_req}),
        .lastGrant  (lastGrant),
        .grantValid (grantValid),
        .winner     (winner)
    );

    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            state      <= IDLE;
            lastGrant  <= MASTER1;
            latchId    <= MASTER0;
            latchAddr  <= '0;
            latchWe    <= 1'b0;
            latchWdata <= '0;
            rdHold0    <= '0;
            rdHold1    <= '0;
        end else begin
            state <= nextState;
            if (grantNow) begin
                lastGrant  <= winner;
                latchId    <= winner;
                latchAddr  <= (winner == MASTER1) ? m1_addr[ADDR_W+1:2] : m0_addr[ADDR_W+1:2];
                latchWe    <= (winner == MASTER1) ? m1_we : m0_we;
                latchWdata <= (winner == MASTER1) ? m1_wdata : m0_wdata;
            end
            if (rdLoad) begin
                if (latchId == MASTER1) begin
                    rdHold1 <= ram_rdata;
                end else begin
                    rdHold0 <= ram_rdata;
                end
            end
        end
    end

    always_comb begin
        nextState = state;
        grantNow  = 1'b0;
        ram_we    = 1'b0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        rdLoad    = 1'b0;
        case (state)
            IDLE: begin
                if (grantValid) begin
                    grantNow  = 1'b1;
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                ram_we    = latchWe;
                nextState = RESP;
            end
            RESP: begin
                m0_ack    = (latchId == MASTER0);
                m1_ack    = (latchId == MASTER1);
                rdLoad    = ~latchWe;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign ram_addr  = latchAddr;
    assign ram_wdata = latchWdata;

    // RAM read data is live during the ack cycle, then held in the per-master register.
    assign m0_rdata = (rdLoad && latchId == MASTER0) ? ram_rdata : rdHold0;
    assign m1_rdata = (rdLoad && latchId == MASTER1) ? ram_rdata : rdHold1;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: directed scenarios then random traffic, checked against
// a transaction-level model (3-cycle bus slots, round-robin ties, shadow memory).
module tb_ram_bus_arbiter;

    logic        CoreClock;
    logic        Reset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic        m0_we, m1_we;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;

    logic        txReq   [0:1];
    logic [31:0] txAddr  [0:1];
    logic        txWe    [0:1];
    logic [31:0] txWdata [0:1];

    assign m0_req = txReq[0];   assign m1_req = txReq[1];
    assign m0_addr = txAddr[0]; assign m1_addr = txAddr[1];
    assign m0_we = txWe[0];     assign m1_we = txWe[1];
    assign m0_wdata = txWdata[0]; assign m1_wdata = txWdata[1];

    ram_bus_arbiter dut (
        .CoreClock (CoreClock),
        .Reset     (Reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_we     (m0_we),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_we     (m1_we),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    initial CoreClock = 1'b0;
    always #5 CoreClock = ~CoreClock;

    // RAM macro stand-in: registered read, write on rising edge.
    logic [31:0] ramMem [0:16383];
    always @(posedge CoreClock) begin
        if (ram_we) ramMem[ram_addr] <= ram_wdata;
        ram_rdata <= ramMem[ram_addr];
    end

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int          slot;          // 0 free, 1 RAM access cycle, 2 ack cycle, 3 turnaround
    bit          mLast;
    bit          mWin;
    bit          mWe;
    logic [13:0] mAddr;
    logic [31:0] mWdata;
    logic [31:0] mRdExp;
    logic [31:0] refRd [0:1];
    logic [31:0] refMem [0:16383];
    bit          expAck [0:1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic stepCycle();
        int w;
        if (Reset) begin
            if (slot == 1 && mWe) refMem[mAddr] = mWdata;
            slot = 0; mLast = 1'b1; mWe = 1'b0; mAddr = '0; mWdata = '0;
            refRd[0] = '0; refRd[1] = '0;
        end else begin
            if (slot == 1) begin
                mRdExp = refMem[mAddr];
                if (mWe) refMem[mAddr] = mWdata;
            end
            if (slot == 2 && !mWe) refRd[mWin] = mRdExp;
            if (slot == 0 || slot == 3) begin
                if (txReq[0] || txReq[1]) begin
                    mWin   = (txReq[0] && txReq[1]) ? ~mLast : txReq[1];
                    mLast  = mWin;
                    w      = int'(mWin);
                    mAddr  = txAddr[w][15:2];
                    mWe    = txWe[w];
                    mWdata = txWdata[w];
                    slot   = 1;
                end else begin
                    slot = 0;
                end
            end else begin
                slot++;
            end
        end
        @(posedge CoreClock);
        #1;
        expAck[0] = (slot == 2) && !mWin;
        expAck[1] = (slot == 2) && mWin;
        chk("ram_we", 32'(ram_we), 32'((slot == 1) && mWe));
        chk("ram_addr", 32'(ram_addr), 32'(mAddr));
        chk("ram_wdata", ram_wdata, mWdata);
        chk("m0_ack", 32'(m0_ack), 32'(expAck[0]));
        chk("m1_ack", 32'(m1_ack), 32'(expAck[1]));
        chk("m0_rdata", m0_rdata, (expAck[0] && !mWe) ? mRdExp : refRd[0]);
        chk("m1_rdata", m1_rdata, (expAck[1] && !mWe) ? mRdExp : refRd[1]);
    endtask

    task automatic setTx(input int i, input logic req, input logic [31:0] addr,
                         input logic we, input logic [31:0] wdata);
        txReq[i] = req; txAddr[i] = addr; txWe[i] = we; txWdata[i] = wdata;
    endtask

    task automatic newRandTx(input int i);
        setTx(i, 1'b1, ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 15)) << 2),
              1'($urandom_range(0, 1)), $urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int ackOrder[$];
        int ackCyc[$];
        int activity;
        int idleCnt [0:1];
        bit ackPrev [0:1];

        for (int a = 0; a < 16384; a++) begin
            ramMem[a] = '0;
            refMem[a] = '0;
        end
        slot = 0; mLast = 1'b1; mWin = 1'b0; mWe = 1'b0; mAddr = '0; mWdata = '0;
        mRdExp = '0; refRd[0] = '0; refRd[1] = '0;
        setTx(0, 1'b0, 32'h0, 1'b0, 32'h0);
        setTx(1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset state.
        Reset = 1'b1;
        stepCycle();
        stepCycle();
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        Reset = 1'b0;
        stepCycle();

        // M0 write 0x10 <- DEADBEEF.
        setTx(0, 1'b1, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
        stepCycle();
        chk("wr_ram_we", 32'(ram_we), 32'h1);
        chk("wr_ram_addr", 32'(ram_addr), 32'h4);
        stepCycle();
        chk("wr_m0_ack", 32'(m0_ack), 32'h1);
        chk("wr_m1_ack", 32'(m1_ack), 32'h0);
        stepCycle();
        txReq[0] = 1'b0;
        stepCycle();

        // M1 read 0x10.
        setTx(1, 1'b1, 32'h0000_0010, 1'b0, 32'h0);
        stepCycle();
        stepCycle();
        chk("rd_m1_ack", 32'(m1_ack), 32'h1);
        chk("rd_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
        chk("rd_m0_rdata", m0_rdata, 32'h0);
        stepCycle();
        txReq[1] = 1'b0;
        stepCycle();

        // Both masters held for four transactions.
        setTx(0, 1'b1, 32'h0000_0020, 1'b1, 32'h1234_5678);
        setTx(1, 1'b1, 32'h0000_0020, 1'b0, 32'h0);
        for (int k = 0; k < 12; k++) begin
            stepCycle();
            chk("tie_no_overlap", 32'(m0_ack & m1_ack), 32'h0);
            if (m0_ack) begin ackOrder.push_back(0); ackCyc.push_back(k); end
            if (m1_ack) begin ackOrder.push_back(1); ackCyc.push_back(k); end
        end
        txReq[0] = 1'b0; txReq[1] = 1'b0;
        stepCycle();
        chk("tie_ack_count", 32'(ackOrder.size()), 32'd4);
        for (int k = 0; k < ackOrder.size() && k < 4; k++)
            chk("tie_grant_order", 32'(ackOrder[k]), 32'(k % 2));
        for (int k = 1; k < ackCyc.size(); k++)
            chk("tie_ack_spacing", 32'(ackCyc[k] - ackCyc[k-1]), 32'd3);

        // Upper address bits ignored.
        setTx(0, 1'b1, 32'hFFFF_0008, 1'b0, 32'h0);
        stepCycle();
        chk("addr_mask", 32'(ram_addr), 32'h2);
        stepCycle();
        stepCycle();
        txReq[0] = 1'b0;
        stepCycle();

        // Reset during the RAM-access cycle of an M1 write.
        setTx(1, 1'b1, 32'h0000_0030, 1'b1, 32'hCAFE_F00D);
        stepCycle();
        chk("rst_mid_issue_we", 32'(ram_we), 32'h1);
        Reset = 1'b1;
        txReq[1] = 1'b0;
        stepCycle();
        chk("rst_mid_ram_we", 32'(ram_we), 32'h0);
        chk("rst_mid_m1_ack", 32'(m1_ack), 32'h0);
        chk("rst_mid_ram_written", ramMem[12], 32'hCAFE_F00D);
        Reset = 1'b0;
        setTx(0, 1'b1, 32'h0000_0010, 1'b0, 32'h0);
        setTx(1, 1'b1, 32'h0000_0030, 1'b0, 32'h0);
        stepCycle();
        stepCycle();
        chk("rst_tie_m0_ack", 32'(m0_ack), 32'h1);
        chk("rst_tie_m1_ack", 32'(m1_ack), 32'h0);
        stepCycle();
        txReq[0] = 1'b0;
        stepCycle();
        stepCycle();
        chk("rst_m1_ack", 32'(m1_ack), 32'h1);
        chk("rst_m1_rdata", m1_rdata, 32'hCAFE_F00D);
        stepCycle();
        txReq[1] = 1'b0;

        // Idle bus.
        activity = 0;
        for (int k = 0; k < 10; k++) begin
            stepCycle();
            activity += int'(ram_we) + int'(m0_ack) + int'(m1_ack);
        end
        chk("idle_activity", 32'(activity), 32'h0);

        // Random traffic from both masters.
        idleCnt[0] = 0; idleCnt[1] = 0;
        ackPrev[0] = 1'b0; ackPrev[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            stepCycle();
            chk("rand_no_overlap", 32'(m0_ack & m1_ack), 32'h0);
            for (int i = 0; i < 2; i++) begin
                if (ackPrev[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        newRandTx(i);
                    end else begin
                        txReq[i] = 1'b0;
                        idleCnt[i] = int'($urandom_range(0, 4));
                    end
                end else if (!txReq[i]) begin
                    if (idleCnt[i] == 0) newRandTx(i);
                    else idleCnt[i]--;
                end
                ackPrev[i] = expAck[i];
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_bus_arbiter.md
# ram_bus_arbiter

Two-master arbiter that shares the single-port on-chip data RAM between the CPU data port (master 0) and a second requester (master 1: boot loader / debug DMA). It sits between the memory controller's RAM-side bus and the RAM macro, which has a registered (1-cycle) synchronous read. It serialises accesses with a 3-state FSM and round-robin priority, and returns per-master acknowledge and read data.

## Interface
Parameters:
- ADDR_W, 14, RAM word-address width (byte address bits [ADDR_W+1:2])
- DATA_W, 32, data word width

Ports:
- CoreClock  in  1  single clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  access request; held high with stable addr/we/wdata until matching ack
- m0_addr, m1_addr  in  32  byte address; only [ADDR_W+1:2] used, others ignored
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_wdata, m1_wdata  in  DATA_W  write data
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  DATA_W  read data, valid when the ack is high; holds its value otherwise
- ram_addr  out  ADDR_W  RAM word address
- ram_wdata  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_rdata  in  DATA_W  RAM read data, one cycle after the address is presented

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset → IDLE.
- IDLE:
  - No requests: stay in IDLE.
  - Any request: choose a winner, latch winner id, addr[ADDR_W+1:2], we, wdata → ISSUE.
- Arbitration is round-robin on a 1-bit last_grant register.
  - Single requester always wins.
  - Both requesting: grant the master ≠ last_grant.
  - last_grant updates on every grant. Reset value 1, so M0 wins the first tie.
- ISSUE:
  - Drive ram_addr/ram_wdata from the latched values.
  - ram_we = latched we.
  - Unconditionally → RESP.
- RESP:
  - Pulse the winner's ack.
  - For reads, load the winner's rdata from ram_rdata. The other master's rdata is unchanged.
  - → IDLE. Requests are not sampled in RESP.
- Masters drop or re-present req in the cycle after ack. A req still high in IDLE is a new request.
- No starvation: with both masters requesting continuously, grants strictly alternate.
- ram_addr/ram_wdata hold their last value outside ISSUE. ram_we is 0 outside ISSUE.

## Timing
- Reset values:
  - State IDLE, last_grant = 1.
  - All acks 0, ram_we 0.
  - ram_addr 0, ram_wdata 0.
  - m0_rdata/m1_rdata 0.
- Latency: req sampled in IDLE at edge N. ram_we/ram_addr are valid during cycle N+1. The ack is high during cycle N+2.
- Read and write latency are identical.
- Throughput: one transaction per 3 cycles. Back-to-back requests see their next grant at N+3.
- Simultaneous ack to both masters never occurs. At most one ack is high per cycle.
- Reset mid-operation:
  - The next edge forces IDLE, acks 0 and ram_we 0.
  - A write whose ISSUE cycle coincided with the Reset edge is allowed to complete in RAM but is never acked.
- A req that drops before ack is a protocol violation. The behaviour is undefined and the bench must not generate it.

## Structure
- Shared package trashbin_bus_pkg holds:
  - the FSM state enum (IDLE/ISSUE/RESP)
  - the master-id type
  - constants RAM_ADDR_W = 14 and BUS_DATA_W = 32
- One natural sub-module, rr_arb2: combinational 2-way round-robin winner select from req[1:0] and last_grant.
- The FSM and latches live in ram_bus_arbiter.

## Test plan
- Reset, then M0 write addr 0x0000_0010 data 0xDEADBEEF:
  - ram_we = 1 and ram_addr = 4 in cycle N+1.
  - m0_ack in N+2; m1_ack stays 0.
- M1 read of addr 0x10 after the above → m1_ack at N+2 with m1_rdata = 0xDEADBEEF; m0_rdata unchanged.
- M0 and M1 request in the same cycle, both held continuously for 4 transactions:
  - grant order M0, M1, M0, M1.
  - acks 3 cycles apart, never overlapping.
- Address bits: M0 read 0xFFFF_0008 → ram_addr = 2 (upper bits ignored).
- Reset asserted during ISSUE of an M1 write:
  - next cycle state IDLE, ram_we = 0, no m1_ack.
  - the first tie after reset goes to M0.
- Idle bus, no req for 10 cycles → ram_we stays 0 and no ack pulses.
